// File: rtl/tx_pkg.sv
// Shared definitions for the serial transmit responder: state encoding and line idle level.
package tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOADED = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOADED = ST_LOADED,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP,
        DONE   = ST_DONE
    } tx_state_e;

    // States during which a frame occupies the serial line.
    function automatic logic is_busy_state(input tx_state_e s);
        return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
    endfunction

endpackage

// File: rtl/tx_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module tx_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_end_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: cleared at frame start and outside frames, wraps at each bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = en_i && !clr_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/serial_tx_responder.sv
// Transmit responder: latches a parallel word, then sends it as a framed LSB-first serial
// stream (start, data, optional even parity, stop) and pulses Tx_DONE when the frame ends.
module serial_tx_responder
    import tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PARALLEL_LOAD,
    input  logic                  Tx_DATA,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic                  TX_OUT,
    output logic                  Tx_DONE,
    output logic                  TX_BUSY
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  parity_q, parity_d;
    logic                  tx_out_q, tx_out_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  frame_start;
    logic                  baud_en;
    logic                  bit_end;

    assign frame_start = (state_q == LOADED) && !PARALLEL_LOAD && Tx_DATA;
    assign baud_en     = is_busy_state(state_q);

    tx_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .clr_i    (frame_start),
        .en_i     (baud_en),
        .bit_end_o(bit_end)
    );

    // Next-state logic; outputs are decoded from the next state so they register in step.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_out_d  = TX_IDLE_LEVEL;
        done_d    = 1'b0;
        busy_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (PARALLEL_LOAD) begin
                    shift_d  = DATA_IN;
                    parity_d = ^DATA_IN;
                    state_d  = LOADED;
                end else begin
                    state_d = IDLE;
                end
            end
            LOADED: begin
                if (PARALLEL_LOAD) begin
                    shift_d  = DATA_IN;
                    parity_d = ^DATA_IN;
                    state_d  = LOADED;
                end else if (Tx_DATA) begin
                    bit_cnt_d = '0;
                    state_d   = START;
                end else begin
                    state_d = LOADED;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = DONE;
                end else begin
                    state_d = STOP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = parity_q;
            default: tx_out_d = TX_IDLE_LEVEL;
        endcase
        done_d = (state_d == DONE);
        busy_d = is_busy_state(state_d);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_out_q  <= TX_IDLE_LEVEL;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_out_q  <= tx_out_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign TX_OUT  = tx_out_q;
    assign Tx_DONE = done_q;
    assign TX_BUSY = busy_q;

endmodule

// File: tb/tb_serial_tx_responder.sv
// Directed bench: three responders (CPB=4 no parity, CPB=4 even parity, CPB=1) share stimulus.
module tb_serial_tx_responder;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       PARALLEL_LOAD = 1'b0;
    logic       Tx_DATA = 1'b0;
    logic [7:0] DATA_IN = 8'h00;
    logic [2:0] tx_v, done_v, busy_v;

    int checks = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    serial_tx_responder #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_p0 (
        .CLK(CLK), .RESET(RESET), .PARALLEL_LOAD(PARALLEL_LOAD), .Tx_DATA(Tx_DATA),
        .DATA_IN(DATA_IN), .TX_OUT(tx_v[0]), .Tx_DONE(done_v[0]), .TX_BUSY(busy_v[0]));

    serial_tx_responder #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_p1 (
        .CLK(CLK), .RESET(RESET), .PARALLEL_LOAD(PARALLEL_LOAD), .Tx_DATA(Tx_DATA),
        .DATA_IN(DATA_IN), .TX_OUT(tx_v[1]), .Tx_DONE(done_v[1]), .TX_BUSY(busy_v[1]));

    serial_tx_responder #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) u_c1 (
        .CLK(CLK), .RESET(RESET), .PARALLEL_LOAD(PARALLEL_LOAD), .Tx_DATA(Tx_DATA),
        .DATA_IN(DATA_IN), .TX_OUT(tx_v[2]), .Tx_DONE(done_v[2]), .TX_BUSY(busy_v[2]));

    function automatic int cpb_of(input int s);
        return (s == 2) ? 1 : 4;
    endfunction

    function automatic int par_of(input int s);
        return (s == 1) ? 1 : 0;
    endfunction

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic do_load(input logic [7:0] w);
        PARALLEL_LOAD = 1'b1;
        DATA_IN = w;
        @(negedge CLK);
        PARALLEL_LOAD = 1'b0;
    endtask

    // Called at a falling edge with a word loaded; drives Tx_DATA and checks the whole frame.
    task automatic run_frame(input int s, input logic [7:0] w, input bit inject,
                             input string name, output logic [10:0] got);
        int cpb = cpb_of(s);
        int n = 10 + par_of(s);
        int bad = 0, done_cnt = 0, done_at = -1, busy_cnt = 0;
        logic [10:0] exp_f = '0;
        got = '0;
        exp_f[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_f[1+i] = w[i];
        if (par_of(s) == 1) exp_f[9] = ^w;
        exp_f[n-1] = 1'b1;

        Tx_DATA = 1'b1;
        @(negedge CLK);
        Tx_DATA = 1'b0;
        for (int j = 0; j < n*cpb + 4; j++) begin
            if (inject) begin
                PARALLEL_LOAD = (j >= 2*cpb) && (j < 4*cpb);
                DATA_IN = 8'hFF;
            end
            if (j < n*cpb) begin
                if (tx_v[s] !== exp_f[j/cpb]) bad++;
                if ((j % cpb) == cpb - 1) got[j/cpb] = tx_v[s];
            end else begin
                if (tx_v[s] !== 1'b1) bad++;
            end
            if (busy_v[s] === 1'b1) busy_cnt++;
            if (done_v[s] === 1'b1) begin
                done_cnt++;
                done_at = j;
            end
            @(negedge CLK);
        end
        PARALLEL_LOAD = 1'b0;

        checks++;
        if (got !== exp_f) $display("FAIL %s_bits: got %b expected %b", name, got, exp_f);
        else passed++;
        checks++;
        if (bad !== 0) $display("FAIL %s_line: %0d wrong cycles, expected 0", name, bad);
        else passed++;
        checks++;
        if (done_cnt !== 1) $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt);
        else passed++;
        checks++;
        if (done_at !== n*cpb) $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_at, n*cpb);
        else passed++;
        checks++;
        if (busy_cnt !== n*cpb) $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cnt, n*cpb);
        else passed++;
    endtask

    // Counts cycles where the chosen instance is not idle-quiet (line high, no busy, no done).
    task automatic watch_quiet(input int s, input int cycles, input string name);
        int bad = 0;
        for (int j = 0; j < cycles; j++) begin
            if (tx_v[s] !== 1'b1 || busy_v[s] !== 1'b0 || done_v[s] !== 1'b0) bad++;
            @(negedge CLK);
        end
        checks++;
        if (bad !== 0) $display("FAIL %s: %0d active cycles, expected 0", name, bad);
        else passed++;
    endtask

    task automatic test_reset();
        logic [2:0] idle_v;
        @(negedge CLK);
        idle_v = {busy_v[0], done_v[0], tx_v[0]};
        checks++;
        if (idle_v !== 3'b001) $display("FAIL reset_outputs: got %b expected 001", idle_v);
        else passed++;
        RESET = 1'b0;
        @(negedge CLK);
        do_load(8'hA5);
        Tx_DATA = 1'b1;
        @(negedge CLK);
        Tx_DATA = 1'b0;
        repeat (10) @(negedge CLK);
        checks++;
        if ({busy_v[0], tx_v[0]} !== 2'b10) $display("FAIL mid_data_state: got %b expected 10", {busy_v[0], tx_v[0]});
        else passed++;
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({busy_v[0], done_v[0], tx_v[0]} !== 3'b001)
            $display("FAIL async_reset: got %b expected 001", {busy_v[0], done_v[0], tx_v[0]});
        else passed++;
        @(negedge CLK);
        RESET = 1'b0;
        Tx_DATA = 1'b1;
        @(negedge CLK);
        Tx_DATA = 1'b0;
        watch_quiet(0, 50, "reset_cut_frame");
    endtask

    task automatic test_frame_a5();
        logic [10:0] got;
        pulse_reset();
        do_load(8'hA5);
        run_frame(0, 8'hA5, 1'b0, "a5", got);
        checks++;
        if (got[9:0] !== 10'b11_0100_1010) $display("FAIL a5_pattern: got %b expected 1101001010", got[9:0]);
        else passed++;
        Tx_DATA = 1'b1;
        @(negedge CLK);
        Tx_DATA = 1'b0;
        watch_quiet(0, 20, "word_consumed");
    endtask

    task automatic test_parity();
        logic [10:0] got;
        pulse_reset();
        do_load(8'h07);
        run_frame(1, 8'h07, 1'b0, "par07", got);
        checks++;
        if (got[9] !== 1'b1) $display("FAIL par07_bit: got %b expected 1", got[9]);
        else passed++;
        do_load(8'h03);
        run_frame(1, 8'h03, 1'b0, "par03", got);
        checks++;
        if (got[9] !== 1'b0) $display("FAIL par03_bit: got %b expected 0", got[9]);
        else passed++;
    endtask

    task automatic test_no_load();
        pulse_reset();
        Tx_DATA = 1'b1;
        @(negedge CLK);
        Tx_DATA = 1'b0;
        watch_quiet(0, 50, "tx_without_load");
    endtask

    task automatic test_load_priority();
        logic [10:0] got;
        pulse_reset();
        do_load(8'h11);
        PARALLEL_LOAD = 1'b1;
        Tx_DATA = 1'b1;
        DATA_IN = 8'h3C;
        @(negedge CLK);
        PARALLEL_LOAD = 1'b0;
        Tx_DATA = 1'b0;
        watch_quiet(0, 3, "load_priority_stay");
        run_frame(0, 8'h3C, 1'b0, "reload3c", got);
    endtask

    task automatic test_load_during_data();
        logic [10:0] got;
        pulse_reset();
        do_load(8'h00);
        run_frame(0, 8'h00, 1'b1, "ignore_load", got);
    endtask

    task automatic test_back_to_back();
        logic [10:0] got;
        pulse_reset();
        do_load(8'h81);
        run_frame(2, 8'h81, 1'b0, "cpb1_81", got);
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity();
        test_no_load();
        test_load_priority();
        test_load_during_data();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
